// File: rtl/gru_pkg.sv
// Shared definitions for the GRU sequencer: phase codes, FSM encoding and
// a constant-foldable ceil(log2) used to size counters and address fields.
package gru_pkg;

  localparam logic [1:0] PH_Z    = 2'd0;
  localparam logic [1:0] PH_R    = 2'd1;
  localparam logic [1:0] PH_C    = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_X = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/gru_phase_timer.sv
// Loadable down-counter timing one gate phase or the drain interval.
// The caller loads (interval - 1); tc is high on the final cycle of the
// interval while the timer is enabled.
module gru_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/gru_seq_ctrl.sv
// Sequencer for one GRU cell: takes x vectors, steps the cell through the
// z/r/c gate phases, captures the new hidden state after the cell pipeline
// drains, hands it downstream and feeds it back as h_prev.
module gru_seq_ctrl
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H          = 4,
  parameter int X          = 4,
  parameter int STEP_CYC   = 3,
  parameter int DRAIN_CYC  = 2,
  parameter int LEN_W      = 8
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic                    use_h_init,
  input  logic [H*DATA_WIDTH-1:0] h_init,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [X*DATA_WIDTH-1:0] x_in,
  output logic [X*DATA_WIDTH-1:0] cell_x,
  output logic [H*DATA_WIDTH-1:0] cell_h_prev,
  output logic                    cell_en,
  output logic [1:0]              cell_phase,
  output logic [clog2(3*H):0]     w_row_base,
  input  logic [H*DATA_WIDTH-1:0] cell_h_new,
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic [H*DATA_WIDTH-1:0] h_out,
  output logic                    busy,
  output logic                    done
);

  localparam int WRB_W = clog2(3*H) + 1;
  localparam int TMAX  = (STEP_CYC > DRAIN_CYC) ? STEP_CYC : DRAIN_CYC;
  localparam int CNT_W = clog2(TMAX) + 1;

  state_t                  state, state_nxt;
  logic [1:0]              phase;
  logic [LEN_W-1:0]        steps_left;
  logic [H*DATA_WIDTH-1:0] h_reg;

  logic             tmr_en, tmr_load, tmr_tc;
  logic [CNT_W-1:0] tmr_val;
  logic             start_ok, x_hs, run_tc, cap, h_hs;

  // Qualified events; abort suppresses every datapath update in its cycle.
  assign start_ok = (state == S_IDLE)   && start && !abort && (seq_len != '0);
  assign x_hs     = (state == S_WAIT_X) && x_valid && !abort;
  assign run_tc   = (state == S_RUN)    && tmr_tc && !abort;
  assign cap      = (state == S_DRAIN)  && tmr_tc && !abort;
  assign h_hs     = (state == S_OUT)    && h_ready && !abort;

  assign tmr_en   = (state == S_RUN) || (state == S_DRAIN);
  assign tmr_load = x_hs || run_tc;
  assign tmr_val  = (run_tc && (phase == PH_C)) ? CNT_W'(DRAIN_CYC - 1)
                                                : CNT_W'(STEP_CYC - 1);

  gru_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .en       (tmr_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = (seq_len != '0) ? S_WAIT_X : S_FIN;
        S_WAIT_X: if (x_valid) state_nxt = S_RUN;
        S_RUN:    if (tmr_tc && (phase == PH_C)) state_nxt = S_DRAIN;
        S_DRAIN:  if (tmr_tc) state_nxt = S_OUT;
        S_OUT:    if (h_ready) state_nxt = (steps_left == LEN_W'(1)) ? S_FIN : S_WAIT_X;
        S_FIN:    state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state and the registered phase.
  always_comb begin
    x_ready    = (state == S_WAIT_X);
    cell_en    = (state == S_RUN);
    cell_phase = cell_en ? phase : PH_IDLE;
    w_row_base = cell_en ? (WRB_W'(phase) * WRB_W'(H)) : '0;
    h_valid    = (state == S_OUT);
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
  end

  // Operand, phase, step-count and result registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cell_x     <= '0;
      h_reg      <= '0;
      h_out      <= '0;
      phase      <= PH_Z;
      steps_left <= '0;
    end else begin
      if (start_ok) begin
        h_reg      <= use_h_init ? h_init : '0;
        steps_left <= seq_len;
      end
      if (x_hs) begin
        cell_x <= x_in;
        phase  <= PH_Z;
      end else if (run_tc && (phase != PH_C)) begin
        phase <= phase + 1'b1;
      end
      if (cap) begin
        h_reg <= cell_h_new;
        h_out <= cell_h_new;
      end
      if (h_hs) steps_left <= steps_left - 1'b1;
    end
  end

  assign cell_h_prev = h_reg;

endmodule

// File: doc/gru_seq_ctrl.md
Name: gru_seq_ctrl

Overview:
Sequencer that drives one GRU cell datapath over a sequence of input vectors. It accepts x vectors with a valid/ready handshake and holds the x and h_prev operands stable. It steps the cell through its three gate phases (update z, reset r, candidate c) with a phase code and weight-row base for the weight store. It captures each new hidden state, presents it downstream with valid/ready, and feeds it back as h_prev for the next timestep.

Parameters:
DATA_WIDTH, 8, bits per vector element (signed)
H, 4, hidden vector length
X, 4, input vector length
STEP_CYC, 3, cycles each gate phase is held (cell pipeline depth)
DRAIN_CYC, 2, cycles after phase c before cell_h_new is valid
LEN_W, 8, width of sequence-length field

Ports:
clk1  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a sequence (ignored unless IDLE)
abort  in  1  synchronous: return to IDLE, no output
seq_len  in  LEN_W  number of timesteps, sampled on start
use_h_init  in  1  sampled on start: 1 = h_init, 0 = zeros
h_init  in  H*DATA_WIDTH  initial hidden state
x_valid  in  1  input vector valid
x_ready  out  1  controller can accept x
x_in  in  X*DATA_WIDTH  input vector
cell_x  out  X*DATA_WIDTH  latched x to the cell
cell_h_prev  out  H*DATA_WIDTH  hidden-state feedback to the cell
cell_en  out  1  cell phase active
cell_phase  out  2  0 = z, 1 = r, 2 = c, 3 = idle
w_row_base  out  log2(3H)+1  cell_phase*H, weight-store row base
cell_h_new  in  H*DATA_WIDTH  cell output hidden state
h_valid  out  1  h_out valid
h_ready  in  1  downstream accepts h_out
h_out  out  H*DATA_WIDTH  captured hidden state
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset values: state IDLE; x_ready=0, cell_en=0, cell_phase=3, w_row_base=0, h_valid=0, done=0, busy=0. cell_x, cell_h_prev, h_out and all counters are 0.
- FSM states: IDLE, WAIT_X, RUN, DRAIN, OUT, FIN.
- IDLE:
  - On start with seq_len>0: load h_reg from h_init (if use_h_init) or 0, load steps_left=seq_len, go to WAIT_X.
  - On start with seq_len=0: go to FIN.
- WAIT_X:
  - x_ready=1.
  - On x_valid&x_ready: latch x_in into cell_x, clear phase counter and phase, go to RUN.
- RUN:
  - cell_en=1 and cell_phase driven from the registered phase.
  - Each phase is held STEP_CYC cycles, in order z, r, c.
  - After the last cycle of c, go to DRAIN.
- DRAIN:
  - cell_en=0, cell_phase=3, held DRAIN_CYC cycles.
  - On the last DRAIN cycle, register cell_h_new into h_out and into h_reg (cell_h_prev).
  - Then go to OUT.
- OUT:
  - h_valid=1. h_out holds stable until h_ready.
  - On handshake, decrement steps_left. If it reaches 0 go to FIN, else go to WAIT_X.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Handshake in cycle n gives RUN cycles n+1 to n+3*STEP_CYC.
  - h_valid is first high in cycle n+1+3*STEP_CYC+DRAIN_CYC; with defaults, n+12.
- cell_h_prev changes only at DRAIN capture or at start. cell_x changes only at x handshake.
- The controller adds no arithmetic. w_row_base = phase*H, zero-extended.
- Boundaries:
  - abort has priority over every transition except reset. It clears all valids and gives no done pulse.
  - start while busy is ignored.
  - x_valid outside WAIT_X: x_ready=0, no latch.
  - h_ready with h_valid=0 has no effect.
  - seq_len=2^LEN_W-1 must complete without counter wrap.
  - Reset mid-sequence returns all outputs to reset values immediately (asynchronous).

Decomposition:
- Package gru_pkg holds:
  - phase constants PH_Z=0, PH_R=1, PH_C=2, PH_IDLE=3;
  - the state encoding;
  - a clog2 function for counter widths.
- One natural sub-module, gru_phase_timer: a STEP_CYC/DRAIN_CYC down-counter with a terminal-count pulse, reused for the RUN and DRAIN intervals.

Test Plan:
1. Reset, then start, seq_len=1, use_h_init=0, x handshake at cycle n. Required: cell_phase 0,0,0,1,1,1,2,2,2 in cycles n+1..n+9; cell_h_prev=0; h_valid at n+12 with h_out=cell_h_new; done one cycle after the h handshake.
2. seq_len=3, h_ready held high, model cell_h_new=step index. Required: three outputs 1,2,3; cell_h_prev equals the previous output during each RUN; exactly one done pulse.
3. Backpressure: hold h_ready=0 for 10 cycles in OUT. Required: h_out stable, x_ready=0, no cell_en, and the sequence resumes on release.
4. start with seq_len=0. Required: done one cycle later, no x_ready, no h_valid.
5. abort during RUN phase r. Required: IDLE next cycle, cell_en=0, no done; a new start then runs normally with use_h_init=1, h_init=0x01020304.
6. rst_n asserted in DRAIN. Required: all outputs at reset values immediately; start after release behaves like scenario 1.
